// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - size encodings, FSM states and lane masks for the store merge unit
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        FIN
    } state_t;

    function automatic logic is_narrow(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

    // Size 2'b11 behaves as a word, so any size with bit 1 set needs word alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lane_merge.sv
// rtl/lane_merge.sv - combinational little-endian merge of store data into an old word
module lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] merged_o
);

    logic [31:0] mask;
    logic [4:0]  shift;

    always_comb begin
        mask  = MASK_WORD;
        shift = 5'd0;
        case (size_i)
            SZ_BYTE: begin
                mask  = MASK_BYTE;
                shift = {addr_lo_i, 3'b000};
            end
            SZ_HALF: begin
                mask  = MASK_HALF;
                shift = {addr_lo_i[1], 4'b0000};
            end
            default: begin
                mask  = MASK_WORD;
                shift = 5'd0;
            end
        endcase
        merged_o = (old_word_i & ~(mask << shift)) | ((data_i & mask) << shift);
    end

endmodule

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - store FSM with RMW for narrow stores; STORE_MISALIGN_TRAP_EN enables misalign trap
module store_merge_unit
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              misalign
);

    state_t            state_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic [31:0]       merged_d;
    logic              trap_d;

`ifdef STORE_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap_d   = is_misaligned(req_size, req_addr[1:0]);
    assign misalign = misalign_q;
`else
    assign trap_d   = 1'b0;
    assign misalign = 1'b0;
`endif

    lane_merge u_lane_merge (
        .old_word_i (mem_rdata),
        .data_i     (data_q),
        .size_i     (size_q),
        .addr_lo_i  (addr_lo_q),
        .merged_o   (merged_d)
    );

    assign req_ready = (state_q == IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            addr_lo_q  <= 2'b00;
            data_q     <= 32'd0;
            size_q     <= SZ_BYTE;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wdata_q    <= 32'd0;
            done_q     <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them.
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr_q <= req_addr[ADDR_W-1:2];
                        addr_lo_q  <= req_addr[1:0];
                        data_q     <= req_data;
                        size_q     <= req_size;
                        if (trap_d) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
                            misalign_q <= 1'b1;
`endif
                        end else if (is_narrow(req_size)) begin
                            state_q <= READ;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= WRITE;
                            wr_en_q <= 1'b1;
                            done_q  <= 1'b1;
                            wdata_q <= req_data;
                        end
                    end
                end
                READ: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= WRITE;
                        wr_en_q <= 1'b1;
                        done_q  <= 1'b1;
                        wdata_q <= merged_d;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - scoreboard bench for store_merge_unit against a byte-array memory model
module tb_store_merge_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              misalign;

    always #5 clk = ~clk;

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .done       (done),
        .misalign   (misalign)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          rd;
        bit          trap;
    } exp_t;

    exp_t        sbq[$];
    time         wr_times[$];
    int          total = 0;
    int          bad = 0;
    int          rd_lat = 1;
    bit          rd_seen = 0;
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] mem [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] w);
        return {ref_mem[{w, 2'd3}], ref_mem[{w, 2'd2}], ref_mem[{w, 2'd1}], ref_mem[{w, 2'd0}]};
    endfunction

    task automatic preload(input logic [7:0] w, input logic [31:0] v);
        mem[w] = v;
        for (int i = 0; i < 4; i++) ref_mem[{w, 2'(i)}] = v[8*i +: 8];
    endtask

    // Reference: apply the store to a byte array, then the expected write is the whole word.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input int lat, output int exp_lat);
        exp_t       e;
        bit         trap;
        logic [9:0] b;
        trap = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        trap = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`endif
        if (!trap) begin
            if (sz == 2'd0) begin
                ref_mem[a[9:0]] = d[7:0];
            end else if (sz == 2'd1) begin
                b = a[9:0] & 10'h3FE;
                for (int i = 0; i < 2; i++) ref_mem[b + 10'(i)] = d[8*i +: 8];
            end else begin
                b = a[9:0] & 10'h3FC;
                for (int i = 0; i < 4; i++) ref_mem[b + 10'(i)] = d[8*i +: 8];
            end
        end
        e.addr  = a >> 2;
        e.wdata = ref_word(a[9:2]);
        e.rd    = !trap && (sz < 2'd2);
        e.trap  = trap;
        sbq.push_back(e);
        exp_lat = trap ? 1 : ((sz < 2'd2) ? 2 + lat : 1);
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input int lat, output int waits);
        int exp_lat;
        int k;
        rd_lat = lat;
        model(a, d, sz, lat, exp_lat);
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        k = 1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("done_latency", 32'(k), 32'(exp_lat));
    endtask

    // Memory responder: serves reads after rd_lat cycles, commits writes, and
    // throws in stray rvalid pulses while no read is outstanding.
    initial begin
        logic [7:0] ra;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (mem_wr_en) mem[mem_addr[7:0]] = mem_wdata;
            if (mem_rd_en) begin
                ra = mem_addr[7:0];
                repeat (rd_lat) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = mem[ra];
            end else if ($urandom_range(0, 9) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end
        end
    end

    // Monitor: every write or done pops one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_seen = 1'b0;
            end else begin
                if (mem_rd_en) begin
                    chk("rd_has_txn", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        chk("rd_expected", 32'(sbq[0].rd), 32'd1);
                        chk("rd_addr", 32'(mem_addr), sbq[0].addr);
                    end
                    rd_seen = 1'b1;
                end
                if (mem_wr_en || done || misalign) begin
                    chk("out_has_txn", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("done", 32'(done), 32'd1);
                        chk("misalign", 32'(misalign), 32'(e.trap));
                        chk("wr_en", 32'(mem_wr_en), 32'(!e.trap));
                        chk("read_done", 32'(rd_seen), 32'(e.rd));
                        if (!e.trap) begin
                            chk("wr_addr", 32'(mem_addr), e.addr);
                            chk("wr_data", mem_wdata, e.wdata);
                        end
                    end
                    if (mem_wr_en) wr_times.push_back($time);
                    rd_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int          w;
        int          n;
        exp_t        ab;
        logic [31:0] keep;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = 32'd0;
        req_size  = 2'd0;
        for (int i = 0; i < 256; i++) preload(8'(i), $urandom);

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        store(32'h10, 32'hDEADBEEF, 2'd2, 1, w);
        preload(8'd8, 32'h11223344);
        store(32'h22, 32'h000000AB, 2'd0, 3, w);
        preload(8'd3, 32'h55667788);
        store(32'h0E, 32'h0000CAFE, 2'd1, 2, w);
        preload(8'd0, 32'h01020304);
        store(32'h03, 32'h0000BEEF, 2'd1, 1, w);
        @(negedge clk);
        chk("word_mem", mem[4], 32'hDEADBEEF);
        chk("byte_mem", mem[8], 32'h11AB3344);
        chk("half_mem", mem[3], 32'hCAFE7788);
`ifdef STORE_MISALIGN_TRAP_EN
        chk("misalign_mem", mem[0], 32'h01020304);
`else
        chk("misalign_mem", mem[0], 32'hBEEF0304);
`endif

        store(32'h40, 32'hA1A1A1A1, 2'd2, 1, w);
        store(32'h44, 32'hB2B2B2B2, 2'd2, 1, w);
        chk("b2b_wait", 32'(w), 32'd1);
        n = wr_times.size();
        chk("b2b_gap", (n >= 2) ? 32'(wr_times[n-1] - wr_times[n-2]) : 32'd0, 32'd20);

        // Reset while waiting for read data: the abandoned store must leave no trace.
        @(negedge clk);
        keep = mem[20];
        ab.addr = 32'h14; ab.wdata = 32'd0; ab.rd = 1'b1; ab.trap = 1'b0;
        sbq.push_back(ab);
        rd_lat    = 6;
        req_addr  = 32'h51;
        req_data  = 32'h0000005A;
        req_size  = 2'd0;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
        repeat (8) @(negedge clk);
        chk("midrst_ready_after", 32'(req_ready), 32'd1);
        chk("midrst_nowrite", mem[20], keep);

        for (int t = 0; t < 60; t++) begin
            store($urandom_range(0, 1023), $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(1, 4), w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side counterpart of the load-path width extension. It takes a 32-bit register value plus a byte/halfword/word size and writes only the addressed lanes into word-organised data memory. Word stores are written directly; byte and halfword stores perform a read-modify-write sequence. The block sits between the datapath store port and the data memory, and stalls the core through its request handshake.

## Interface
- `ADDR_W`, default 32: byte-address width; memory word address is `ADDR_W-2` bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit idle; request accepted when `req_valid && req_ready`.
- `req_addr`  in  ADDR_W  byte address.
- `req_data`  in  32  register value; low byte/halfword used for narrow stores.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `mem_addr`  out  ADDR_W-2  word address (`req_addr[ADDR_W-1:2]`, registered).
- `mem_rd_en`  out  1  one-cycle read strobe.
- `mem_rdata`  in  32  read data, valid with `mem_rvalid`.
- `mem_rvalid`  in  1  read data valid; any latency of 1 or more cycles.
- `mem_wr_en`  out  1  one-cycle full-word write strobe.
- `mem_wdata`  out  32  merged word.
- `done`  out  1  one-cycle pulse when the store completes.
- `misalign`  out  1  one-cycle pulse with `done` on a trapped misaligned store (only with the macro).

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, FIN.
- IDLE: `req_ready=1`. On accept, register addr/data/size.
  - Word: go to WRITE.
  - Byte/half: go to READ.
- READ: assert `mem_rd_en` for one cycle, then go to WAIT.
- WAIT: hold until `mem_rvalid`. Capture the merged word, then go to WRITE.
- WRITE: assert `mem_wr_en` with `mem_wdata`, pulse `done`, then go to IDLE.
- FIN: used only for a trapped misalign. Pulse `done` and `misalign`, make no memory access, then go to IDLE.
- Lane rule is little-endian:
  - Byte: `addr[1:0]=k` replaces bits `[8k+7:8k]` with `req_data[7:0]`.
  - Half: `addr[1]=h` replaces bits `[16h+15:16h]` with `req_data[15:0]`.
  - Word: `mem_wdata=req_data`.
- Bytes not addressed are preserved bit-exact from `mem_rdata`.
- A `mem_rvalid` seen outside WAIT is ignored.
- Inputs are sampled only at accept. Changes to `req_*` while busy have no effect.

## Timing
- Reset (async assert, sync release): state IDLE. `req_ready=1`; `mem_rd_en`, `mem_wr_en`, `done`, `misalign` all 0; `mem_addr` and `mem_wdata` are 0.
- Word store accepted at cycle N: `mem_wr_en` and `done` at N+1; `req_ready` back at N+2.
- Narrow store accepted at N: `mem_rd_en` at N+1; `mem_rvalid` at N+1+L (L≥1); `mem_wr_en` and `done` at N+2+L.
- Back-to-back: the next request can be accepted in the cycle after `done`.
- Reset mid-sequence: the sequence is abandoned, no write is issued, and no `done` is produced.
- `mem_addr` is held stable from the read strobe through the write strobe.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - Misaligned requests are trapped: half with `addr[0]=1`, or word with `addr[1:0]≠0`.
  - Trapped requests go IDLE→FIN. `done` and `misalign` pulse at N+1; no memory access.
- `STORE_MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied to 0.
  - Half ignores `addr[0]`; word ignores `addr[1:0]`. Stores proceed normally.

## Structure
- Package `store_pkg` holds:
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`);
  - the FSM state enum;
  - lane-mask constants.
- Sub-module `lane_merge` is purely combinational: (old word, data, size, addr[1:0]) → merged word. The FSM and registers stay in `store_merge_unit`.

## Test plan
- Word store: addr 0x10, data 0xDEADBEEF → `mem_wr_en` at N+1, `mem_addr`=0x4, `mem_wdata`=0xDEADBEEF, no `mem_rd_en`.
- Byte store: addr 0x22, data 0x000000AB, `mem_rdata`=0x11223344, L=3 → `mem_wdata`=0x11AB3344, `done` at N+5.
- Half store: addr 0x0E, data 0x0000CAFE, `mem_rdata`=0x55667788 → `mem_wdata`=0xCAFE7788.
- Misaligned half at addr 0x03:
  - With the macro: `done`+`misalign` at N+1, no memory strobes.
  - Without the macro: `mem_wdata` upper half replaced.
- `rst_n` low during WAIT, then `mem_rvalid` arrives → no `mem_wr_en`, no `done`, `req_ready=1`.
- Two back-to-back word stores → second accepted the cycle after the first `done`; two write strobes two cycles apart.
